// File: rtl/cla_add_arbiter.sv
// Round-robin arbiter sharing one WIDTH-bit adder between two requesters.
// Each granted add runs LSB slice first with the carry chained through the slices.
module cla_add_arbiter #(
    parameter int unsigned WIDTH   = 4,
    parameter int unsigned SLICES  = 2,
    parameter int unsigned TIMEOUT = 15
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      req0,
    input  logic                      req1,
    input  logic [WIDTH*SLICES-1:0]   a0,
    input  logic [WIDTH*SLICES-1:0]   b0,
    input  logic [WIDTH*SLICES-1:0]   a1,
    input  logic [WIDTH*SLICES-1:0]   b1,
    input  logic                      cin0,
    input  logic                      cin1,
    output logic                      done0,
    output logic                      done1,
    output logic [WIDTH*SLICES-1:0]   result,
    output logic                      c_out,
    output logic                      err,
    output logic                      busy,
    output logic                      adder_en,
    output logic [WIDTH-1:0]          adder_a,
    output logic [WIDTH-1:0]          adder_b,
    output logic                      adder_c_in,
    input  logic [WIDTH-1:0]          adder_sum,
    input  logic                      adder_c_out,
    input  logic                      adder_ready
);

    localparam int unsigned OpW = WIDTH * SLICES;
    localparam int unsigned TW  = $clog2(TIMEOUT + 1);
    localparam int unsigned SW  = (SLICES > 1) ? $clog2(SLICES) : 1;

    localparam logic [SW-1:0] LastSlice  = SW'(SLICES - 1);
    localparam logic [TW-1:0] TimerLimit = TW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StWait,
        StDone
    } state_e;

    state_e           state_q, state_d;
    logic             rr_q, rr_d;
    logic             gnt_q, gnt_d;
    logic [OpW-1:0]   a_q, a_d;
    logic [OpW-1:0]   b_q, b_d;
    logic             carry_q, carry_d;
    logic [SW-1:0]    slice_q, slice_d;
    logic [TW-1:0]    timer_q, timer_d;
    logic [OpW-1:0]   result_q, result_d;
    logic             c_out_q, c_out_d;
    logic             err_q, err_d;
    logic             sel;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= StIdle;
            rr_q     <= 1'b0;
            gnt_q    <= 1'b0;
            a_q      <= '0;
            b_q      <= '0;
            carry_q  <= 1'b0;
            slice_q  <= '0;
            timer_q  <= '0;
            result_q <= '0;
            c_out_q  <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            rr_q     <= rr_d;
            gnt_q    <= gnt_d;
            a_q      <= a_d;
            b_q      <= b_d;
            carry_q  <= carry_d;
            slice_q  <= slice_d;
            timer_q  <= timer_d;
            result_q <= result_d;
            c_out_q  <= c_out_d;
            err_q    <= err_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        rr_d     = rr_q;
        gnt_d    = gnt_q;
        a_d      = a_q;
        b_d      = b_q;
        carry_d  = carry_q;
        slice_d  = slice_q;
        timer_d  = timer_q;
        result_d = result_q;
        c_out_d  = c_out_q;
        err_d    = err_q;
        sel      = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (req0 || req1) begin
                    // With both requesting, the rr pointer names the winner.
                    sel      = (req0 && req1) ? rr_q : req1;
                    gnt_d    = sel;
                    a_d      = sel ? a1 : a0;
                    b_d      = sel ? b1 : b0;
                    carry_d  = sel ? cin1 : cin0;
                    slice_d  = '0;
                    result_d = '0;
                    c_out_d  = 1'b0;
                    err_d    = 1'b0;
                    state_d  = StIssue;
                end
            end
            StIssue: begin
                timer_d = '0;
                state_d = StWait;
            end
            StWait: begin
                // Ready takes priority over a timeout landing on the same cycle.
                if (adder_ready) begin
                    result_d[slice_q*WIDTH +: WIDTH] = adder_sum;
                    carry_d = adder_c_out;
                    if (slice_q == LastSlice) begin
                        c_out_d = adder_c_out;
                        state_d = StDone;
                    end else begin
                        slice_d = slice_q + 1'b1;
                        state_d = StIssue;
                    end
                end else if (timer_q == TimerLimit) begin
                    err_d    = 1'b1;
                    result_d = '0;
                    c_out_d  = 1'b0;
                    state_d  = StDone;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            StDone: begin
                rr_d    = ~gnt_q;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    logic driving;
    assign driving    = (state_q == StIssue) || (state_q == StWait);

    assign adder_en   = (state_q == StIssue);
    assign adder_a    = driving ? a_q[slice_q*WIDTH +: WIDTH] : '0;
    assign adder_b    = driving ? b_q[slice_q*WIDTH +: WIDTH] : '0;
    assign adder_c_in = driving ? carry_q : 1'b0;

    assign done0      = (state_q == StDone) && !gnt_q;
    assign done1      = (state_q == StDone) && gnt_q;
    assign err        = (state_q == StDone) && err_q;
    assign busy       = (state_q != StIdle);
    assign result     = result_q;
    assign c_out      = c_out_q;

endmodule

// File: tb/tb_cla_add_arbiter.sv
// Directed bench for cla_add_arbiter with a behavioural adder whose ready delay is adjustable.
module tb_cla_add_arbiter;

    logic       clk = 1'b0;
    logic       reset;
    logic       req0, req1, cin0, cin1;
    logic [7:0] a0, b0, a1, b1;
    logic       done0, done1, c_out, err, busy, adder_en, adder_c_in;
    logic [7:0] result;
    logic [3:0] adder_a, adder_b, adder_sum;
    logic       adder_c_out, adder_ready;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    cla_add_arbiter #(.WIDTH(4), .SLICES(2), .TIMEOUT(15)) dut (
        .clk(clk), .reset(reset),
        .req0(req0), .req1(req1),
        .a0(a0), .b0(b0), .a1(a1), .b1(b1),
        .cin0(cin0), .cin1(cin1),
        .done0(done0), .done1(done1),
        .result(result), .c_out(c_out), .err(err), .busy(busy),
        .adder_en(adder_en), .adder_a(adder_a), .adder_b(adder_b), .adder_c_in(adder_c_in),
        .adder_sum(adder_sum), .adder_c_out(adder_c_out), .adder_ready(adder_ready)
    );

    // Adder model: ready pulses dly cycles after en; dly=0 means never. Ignores reset on purpose.
    int dly = 1;
    int cnt = 0;
    always @(posedge clk) begin
        if (adder_en && dly > 0) cnt <= dly;
        else if (cnt != 0)       cnt <= cnt - 1;
    end
    assign adder_ready = (cnt == 1);
    assign {adder_c_out, adder_sum} = {1'b0, adder_a} + {1'b0, adder_b} + {4'b0, adder_c_in};

    // Monitor: counts adder starts and done pulses, remembers each slice carry-in.
    int   en_cnt = 0, d0_cnt = 0, d1_cnt = 0;
    logic cin_hist [4];
    always @(posedge clk) begin
        #1;
        if (adder_en) begin
            if (en_cnt < 4) cin_hist[en_cnt] = adder_c_in;
            en_cnt++;
        end
        if (done0) d0_cnt++;
        if (done1) d1_cnt++;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Runs one operation for requester who; lat = edges from grant edge (inclusive) to done.
    task automatic do_op(input logic who, input logic [7:0] a, input logic [7:0] b,
                         input logic c, input int budget, output int lat,
                         output logic [7:0] res, output logic co, output logic er,
                         output logic wrong);
        @(negedge clk);
        wrong = 1'b0;
        res = '0; co = 1'b0; er = 1'b0;
        if (who) begin a1 = a; b1 = b; cin1 = c; req1 = 1'b1; end
        else     begin a0 = a; b0 = b; cin0 = c; req0 = 1'b1; end
        lat = 0;
        while (1) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            if ((who ? done0 : done1)) wrong = 1'b1;
            if ((who ? done1 : done0)) begin
                res = result; co = c_out; er = err;
                break;
            end
            if (lat >= budget) begin
                lat = -1;
                break;
            end
        end
        req0 = 1'b0;
        req1 = 1'b0;
    endtask

    typedef struct {
        logic       who;
        logic [7:0] a, b;
        logic       cin;
        logic [7:0] exp_res;
        logic       exp_co;
        logic       exp_c1;
    } vec_t;

    vec_t vecs [6];

    initial begin
        int         lat, t0, t1, tprev;
        logic [7:0] res;
        logic       co, er, wrong;
        logic [7:0] r0, r1;

        vecs[0] = '{1'b0, 8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 1'b0};
        vecs[1] = '{1'b1, 8'h0F, 8'h01, 1'b0, 8'h10, 1'b0, 1'b1};
        vecs[2] = '{1'b1, 8'hFF, 8'h00, 1'b1, 8'h00, 1'b1, 1'b1};
        vecs[3] = '{1'b0, 8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b0};
        vecs[4] = '{1'b0, 8'hA5, 8'h5A, 1'b1, 8'h00, 1'b1, 1'b1};
        vecs[5] = '{1'b1, 8'h37, 8'h49, 1'b1, 8'h81, 1'b0, 1'b1};

        reset = 1'b1; req0 = 0; req1 = 0; cin0 = 0; cin1 = 0;
        a0 = 0; b0 = 0; a1 = 0; b1 = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        chk("reset_outputs", {done0, done1, err, busy, adder_en, adder_c_in, c_out,
                              adder_a, adder_b, result}, '0);

        for (int i = 0; i < 6; i++) begin
            en_cnt = 0;
            d0_cnt = 0;
            d1_cnt = 0;
            do_op(vecs[i].who, vecs[i].a, vecs[i].b, vecs[i].cin, 20, lat, res, co, er, wrong);
            chk($sformatf("vec%0d_latency", i), lat, 5);
            chk($sformatf("vec%0d_result", i), res, vecs[i].exp_res);
            chk($sformatf("vec%0d_cout", i), co, vecs[i].exp_co);
            chk($sformatf("vec%0d_err", i), er, 0);
            chk($sformatf("vec%0d_other_done", i), wrong, 0);
            @(negedge clk);
            chk($sformatf("vec%0d_en_pulses", i), en_cnt, 2);
            chk($sformatf("vec%0d_slice1_cin", i), cin_hist[1], vecs[i].exp_c1);
            chk($sformatf("vec%0d_done_pulses", i), vecs[i].who ? d1_cnt : d0_cnt, 1);
        end

        // Contention twice: pointer is back at req0 after both passes.
        for (int pass = 0; pass < 2; pass++) begin
            @(negedge clk);
            a0 = 8'h21; b0 = 8'h43; cin0 = 0; a1 = 8'hF0; b1 = 8'h20; cin1 = 1;
            req0 = 1; req1 = 1;
            t0 = -1; t1 = -1; r0 = 0; r1 = 0;
            for (int cyc = 1; cyc <= 20; cyc++) begin
                @(posedge clk);
                @(negedge clk);
                if (done0 && t0 < 0) begin t0 = cyc; r0 = result; req0 = 0; end
                if (done1 && t1 < 0) begin t1 = cyc; r1 = result; req1 = 0; end
                if (t0 >= 0 && t1 >= 0) break;
            end
            req0 = 0; req1 = 0;
            chk($sformatf("both%0d_done0_time", pass), t0, 5);
            chk($sformatf("both%0d_done1_time", pass), t1, 11);
            chk($sformatf("both%0d_res0", pass), r0, 8'h64);
            chk($sformatf("both%0d_res1", pass), r1, 8'h11);
        end

        // req1 held continuously: one completion every 6 cycles.
        @(negedge clk);
        a1 = 8'h01; b1 = 8'h02; cin1 = 0; req1 = 1;
        tprev = -1;
        for (int cyc = 1, n = 0; cyc <= 40 && n < 3; cyc++) begin
            @(posedge clk);
            @(negedge clk);
            if (done1) begin
                if (tprev >= 0) chk($sformatf("hold_period%0d", n), cyc - tprev, 6);
                tprev = cyc;
                n++;
            end
        end
        req1 = 0;
        chk("hold_served", (tprev > 0), 1);
        @(negedge clk);

        // Slow adder: ready three cycles after en.
        dly = 3;
        en_cnt = 0;
        do_op(1'b0, 8'h12, 8'h34, 1'b0, 30, lat, res, co, er, wrong);
        chk("slow_latency", lat, 9);
        chk("slow_result", res, 8'h46);
        @(negedge clk);
        chk("slow_en_pulses", en_cnt, 2);

        // Adder never answers: timeout abort.
        dly = 0;
        do_op(1'b0, 8'h12, 8'h34, 1'b0, 40, lat, res, co, er, wrong);
        chk("timeout_latency", lat, 17);
        chk("timeout_err", er, 1);
        chk("timeout_result", {co, res}, 9'h000);
        dly = 1;
        do_op(1'b0, 8'h05, 8'h06, 1'b0, 20, lat, res, co, er, wrong);
        chk("after_timeout_result", {er, co, res}, 10'h00B);

        // Reset while waiting on slice 1; the late ready must be ignored.
        dly = 3;
        en_cnt = 0;
        @(negedge clk);
        a1 = 8'h12; b1 = 8'h34; cin1 = 0; req1 = 1;
        for (int cyc = 0; cyc < 20; cyc++) begin
            @(negedge clk);
            if (en_cnt == 2 && !adder_en) break;
        end
        chk("reset_reached_slice1", en_cnt, 2);
        reset = 1;
        @(negedge clk);
        reset = 0;
        req1 = 0;
        d0_cnt = 0;
        d1_cnt = 0;
        chk("midreset_outputs", {done0, done1, err, busy, adder_en, adder_c_in, c_out,
                                 adder_a, adder_b, result}, '0);
        repeat (6) @(negedge clk);
        chk("midreset_no_done", d0_cnt + d1_cnt, 0);
        chk("midreset_idle", {busy, result}, '0);
        dly = 1;
        do_op(1'b1, 8'h80, 8'h80, 1'b0, 20, lat, res, co, er, wrong);
        chk("after_reset_result", {er, co, res}, 10'h100);
        chk("after_reset_latency", lat, 5);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
